// File: rtl/hazard_pkg.sv
// Shared constants for the scoreboarded hazard unit.
//   FWD_*        : ForwardAE/ForwardBE select encodings
//   *_DEF        : default register-file geometry
package hazard_pkg;

  localparam int unsigned REG_AW_DEF   = 5;
  localparam int unsigned NUM_REGS_DEF = 32;

  localparam logic [1:0] FWD_RF = 2'd0;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'd1;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'd2;  // operand from M-stage result

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count enable, holds at all-ones
//   q          : counter value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage pipeline with a divider scoreboard.
//   Inputs : D/E/M/W register addresses and controls, PCSrcE, dmem_wait,
//            divider completion (div_done/div_rd), cnt_clr
//   Outputs: ForwardAE/BE (E-stage bypass selects), Stall{F,D,E,M},
//            Flush{D,E,W}, div_busy, stall_cnt/flush_cnt perf counters
// All stall/flush/forward outputs are combinational from inputs plus the
// pending-register scoreboard and div_busy flop.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              Rs1UsedD,
  input  logic              Rs2UsedD,
  input  logic              RegWriteD,
  input  logic              DivD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE,
  input  logic              DivE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              dmem_wait,
  input  logic              div_done,
  input  logic [REG_AW-1:0] div_rd,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              div_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if ((rs != '0) && we_m && (rs == rd_m)) begin
      sel = FWD_M;
    end else if ((rs != '0) && we_w && (rs == rd_w)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_d;
  logic                r_div_busy;
  logic                w_div_busy_d;

  logic w_issue;
  logic w_hit_rde;
  logic w_lw_stall;
  logic w_sb_raw;
  logic w_sb_waw;
  logic w_sb_struct;
  logic w_hz_stall;
  logic w_flush_any;

  // Forwarding
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Hazard detection; pending[0] is always 0 so x0 sources never match.
  always_comb begin
    w_hit_rde   = (RdE != '0) &&
                  ((Rs1UsedD && (Rs1D == RdE)) || (Rs2UsedD && (Rs2D == RdE)));
    w_lw_stall  = (ResultSrcE || DivE) && RegWriteE && w_hit_rde;
    w_sb_raw    = (Rs1UsedD && r_pending[Rs1D]) || (Rs2UsedD && r_pending[Rs2D]);
    w_sb_waw    = RegWriteD && r_pending[RdD];
    w_sb_struct = DivD && (r_div_busy || DivE);
    w_hz_stall  = w_lw_stall || w_sb_raw || w_sb_waw || w_sb_struct;
  end

  // Priority: memory wait freezes everything, then redirect, then hazard.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (dmem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // The stalled D instruction is on the wrong path, so redirect wins.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_hz_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Scoreboard next state; issue sets after done clears so a same-cycle
  // done+issue leaves the divider busy.
  assign w_issue = DivE && !dmem_wait;

  always_comb begin
    w_pending_d = r_pending;
    if (div_done) begin
      w_pending_d[div_rd] = 1'b0;
    end
    if (w_issue && (RdE != '0)) begin
      w_pending_d[RdE] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_comb begin
    w_div_busy_d = r_div_busy;
    if (w_issue) begin
      w_div_busy_d = 1'b1;
    end else if (div_done) begin
      w_div_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_div_busy <= 1'b0;
    end else begin
      r_pending  <= w_pending_d;
      r_div_busy <= w_div_busy_d;
    end
  end

  assign div_busy    = r_div_busy;
  assign w_flush_any = FlushD || FlushE;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (StallF),
    .q    (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (w_flush_any),
    .q    (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit_sb.sv
module tb_hazard_unit_sb;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, div_rd;
  logic       Rs1UsedD, Rs2UsedD, RegWriteD, DivD;
  logic       RegWriteE, ResultSrcE, DivE, PCSrcE, RegWriteM, RegWriteW;
  logic       dmem_wait, div_done, cnt_clr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, div_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  hazard_unit_sb #(
    .REG_AW  (5),
    .NUM_REGS(32),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdD       (RdD),
    .Rs1UsedD  (Rs1UsedD),
    .Rs2UsedD  (Rs2UsedD),
    .RegWriteD (RegWriteD),
    .DivD      (DivD),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RegWriteE (RegWriteE),
    .ResultSrcE(ResultSrcE),
    .DivE      (DivE),
    .PCSrcE    (PCSrcE),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .dmem_wait (dmem_wait),
    .div_done  (div_done),
    .div_rd    (div_rd),
    .cnt_clr   (cnt_clr),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .div_busy  (div_busy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mp[32];
  bit mbusy = 1'b0;
  int msc   = 0;
  int mfc   = 0;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, sm, fd, fe, fw;
  } exp_t;

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (rs != 0 && RegWriteM && rs == RdM) return 2'd2;
    if (rs != 0 && RegWriteW && rs == RdW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((Rs1UsedD && Rs1D == r) || (Rs2UsedD && Rs2D == r));
  endfunction

  function automatic exp_t mexp();
    exp_t e;
    bit   hz;
    e    = '0;
    e.fa = mfwd(Rs1E);
    e.fb = mfwd(Rs2E);
    hz   = (ResultSrcE || DivE) && RegWriteE && reads(RdE);
    for (int r = 1; r < 32; r++) if (mp[r] && reads(5'(r))) hz = 1'b1;
    if (RegWriteD && RdD != 0 && mp[RdD]) hz = 1'b1;
    if (DivD && (mbusy || DivE)) hz = 1'b1;
    if (dmem_wait) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
    end else if (PCSrcE) begin
      e.fd = 1; e.fe = 1;
    end else if (hz) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    exp_t e;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) mp[r] <= 1'b0;
      mbusy <= 1'b0;
      msc   <= 0;
      mfc   <= 0;
    end else begin
      e = mexp();
      if (div_done) mp[div_rd] <= 1'b0;
      if (DivE && !dmem_wait && RdE != 0) mp[RdE] <= 1'b1;
      if (DivE && !dmem_wait) mbusy <= 1'b1;
      else if (div_done) mbusy <= 1'b0;
      if (cnt_clr) begin
        msc <= 0;
        mfc <= 0;
      end else begin
        if (e.sf && msc < CMAX) msc <= msc + 1;
        if ((e.fd || e.fe) && mfc < CMAX) mfc <= mfc + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst_n && chk_en) begin
      e = mexp();
      chk("fwdA", ForwardAE, e.fa);
      chk("fwdB", ForwardBE, e.fb);
      chk("stalls", {StallF, StallD, StallE, StallM}, {e.sf, e.sd, e.se, e.sm});
      chk("flushes", {FlushD, FlushE, FlushW}, {e.fd, e.fe, e.fw});
      chk("div_busy", div_busy, mbusy);
      chk("stall_cnt", stall_cnt, msc);
      chk("flush_cnt", flush_cnt, mfc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdD = 0; Rs1UsedD = 0; Rs2UsedD = 0; RegWriteD = 0; DivD = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; RegWriteE = 0; ResultSrcE = 0; DivE = 0; PCSrcE = 0;
    RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0;
    dmem_wait = 0; div_done = 0; div_rd = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_r1(input logic [4:0] r);
    ResultSrcE = 1; RegWriteE = 1; RdE = r; Rs1D = r; Rs1UsedD = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_div_busy", div_busy, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Forwarding
    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; #1;
    chk("fwd_m", ForwardAE, 2);
    tick();
    RegWriteM = 0; #1;
    chk("fwd_w", ForwardAE, 1);
    tick();
    Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs2E = 3; #1;
    chk("fwd_x0", ForwardAE, 0);
    chk("fwd_b_rf", ForwardBE, 0);
    tick();
    idle(); Rs2E = 3; RdW = 3; RegWriteW = 1; #1;
    chk("fwd_b_w", ForwardBE, 1);
    tick();

    // Load-use: exactly one bubble
    idle(); ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; Rs2UsedD = 1; #1;
    chk("lu_stall", {StallF, StallD, FlushE, StallE}, 4'b1110);
    tick();
    ResultSrcE = 0; RegWriteE = 0; RdE = 0; #1;
    chk("lu_release", StallF, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_flush_cnt", flush_cnt, 1);
    ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2UsedD = 0; #1;
    chk("lu_unused", StallF, 0);
    tick();

    // Divide scoreboard on x9
    idle(); DivE = 1; RdE = 9; RegWriteE = 1; #1;
    chk("div_issue_nostall", StallF, 0);
    tick();
    idle(); Rs1D = 9; Rs1UsedD = 1; #1;
    chk("div_busy_set", div_busy, 1);
    chk("div_raw", {StallF, FlushE}, 2'b11);
    tick();
    tick();
    div_done = 1; div_rd = 9; #1;
    chk("div_done_still", StallF, 1);
    tick();
    div_done = 0; #1;
    chk("div_released", StallF, 0);
    chk("div_busy_clr", div_busy, 0);
    chk("div_stall_cnt", stall_cnt, 4);
    chk("div_flush_cnt", flush_cnt, 4);
    tick();

    // Structural and WAW on x12
    idle(); DivE = 1; RdE = 12; RegWriteE = 1; DivD = 1; #1;
    chk("struct_dive", StallF, 1);
    tick();
    idle(); DivD = 1; #1;
    chk("struct_busy", StallF, 1);
    tick();
    DivD = 0; RegWriteD = 1; RdD = 12; #1;
    chk("waw", StallF, 1);
    tick();
    DivD = 1; div_done = 1; div_rd = 12; #1;
    chk("waw_done_still", StallF, 1);
    tick();
    div_done = 0; #1;
    chk("struct_released", StallF, 0);
    chk("struct_stall_cnt", stall_cnt, 8);
    chk("struct_flush_cnt", flush_cnt, 8);
    tick();

    // Priority
    idle(); dmem_wait = 1; PCSrcE = 1; load_use_r1(7); #1;
    chk("wait_stalls", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
    chk("wait_noflush", {FlushD, FlushE}, 2'b00);
    tick();
    dmem_wait = 0; #1;
    chk("redirect_flush", {FlushD, FlushE}, 2'b11);
    chk("redirect_nostall", {StallF, StallD, StallE}, 3'b000);
    tick();
    idle(); dmem_wait = 1; DivE = 1; RdE = 15; RegWriteE = 1; #1;
    chk("prio_stall_cnt", stall_cnt, 9);
    chk("prio_flush_cnt", flush_cnt, 9);
    tick();
    idle(); Rs1D = 15; Rs1UsedD = 1; #1;
    chk("wait_blocks_issue", div_busy, 0);
    chk("wait_no_pending", StallF, 0);
    chk("wait_stall_cnt", stall_cnt, 10);
    tick();

    // Asynchronous reset mid-stall
    idle(); DivE = 1; RdE = 9; RegWriteE = 1;
    tick();
    idle(); Rs1D = 9; Rs1UsedD = 1; #1;
    chk("pre_rst_stall", StallF, 1);
    tick();
    chk("pre_rst_cnt", stall_cnt, 11);
    rst_n = 1'b0; #1;
    chk("arst_div_busy", div_busy, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    chk("arst_pending", StallF, 0);
    rst_n = 1'b1;
    tick();
    div_done = 1; div_rd = 9; #1;
    chk("late_done", StallF, 0);
    tick();
    idle(); #1;
    chk("late_done_busy", div_busy, 0);
    chk("late_done_cnt", stall_cnt, 0);

    // Saturation and clear
    load_use_r1(7);
    repeat (20) tick();
    chk("sat_stall", stall_cnt, CMAX);
    chk("sat_flush", flush_cnt, CMAX);
    tick();
    chk("sat_hold", stall_cnt, CMAX);
    cnt_clr = 1; #1;
    chk("clr_sync", stall_cnt, CMAX);
    tick();
    chk("clr_stall", stall_cnt, 0);
    chk("clr_flush", flush_cnt, 0);
    cnt_clr = 0;
    tick();
    chk("post_clr", stall_cnt, 1);
    idle();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Parametrised successor hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W). It keeps the existing responsibilities: E-stage forwarding select, load-use stall, and taken-branch/jump flush. It adds three things. A register scoreboard for a multi-cycle divider that writes back out of order through its own register-file port. A data-memory wait stall that freezes F..M. Saturating stall/flush performance counters.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_REGS, 32, architectural registers (2**REG_AW); register 0 is never tracked or forwarded
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D, RdD  in  REG_AW  D-stage source/destination addresses
- Rs1UsedD, Rs2UsedD, RegWriteD, DivD  in  1  D-stage source-valid, write-enable, is-divide
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage addresses
- RegWriteE, ResultSrcE, DivE  in  1  E-stage write-enable, is-load, is-divide
- PCSrcE  in  1  branch/jump taken, resolved in E
- RdM, RegWriteM  in  REG_AW/1  M-stage destination
- RdW, RegWriteW  in  REG_AW/1  W-stage destination
- dmem_wait  in  1  M-stage memory access not complete
- div_done  in  1  one-cycle pulse, divider result written this cycle
- div_rd  in  REG_AW  destination of completing divide
- cnt_clr  in  1  synchronous clear of both counters
- ForwardAE, ForwardBE  out  2  0 = register file, 1 = W result, 2 = M result
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  bubble stage register
- div_busy  out  1  divider occupied
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational): ForwardAE is 2 if Rs1E==RdM, RegWriteM, Rs1E!=0. Otherwise 1 if Rs1E==RdW, RegWriteW, Rs1E!=0. Otherwise 0. ForwardBE is the same using Rs2E.
- hitD(r) = (Rs1UsedD & Rs1D==r) | (Rs2UsedD & Rs2D==r), only for r!=0.
- lwStall = (ResultSrcE | DivE) & RegWriteE & hitD(RdE).
- sbStall covers three cases:
  - hitD(r) where pending[r] is set;
  - RegWriteD & pending[RdD] (WAW);
  - DivD & (div_busy | DivE), for structural reasons.
- hzStall = lwStall | sbStall.
- State:
  - pending[NUM_REGS-1:1] is the scoreboard; bit 0 is constant 0.
  - div_busy is a flop.
- Output priority:
  1. dmem_wait=1: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0. A taken branch is held and re-evaluated.
  2. PCSrcE=1: FlushD=FlushE=1 and StallF=StallD=0. The redirect wins over a concurrent hzStall, because the stalled D instruction is on the wrong path.
  3. hzStall=1: StallF=StallD=1 and FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- StallE, StallM and FlushW are asserted only under dmem_wait.
- Divide issue: issueE = DivE & ~dmem_wait. When issueE occurs, div_busy is set, and pending[RdE] is set if RdE!=0.
- div_done clears div_busy and pending[div_rd].
  - Issue and done cannot target the same register in one cycle, because issue is blocked while busy.
  - If both occur (done from one divide, issue from the next in the same cycle), set has priority for div_busy.
- A clear takes effect at the next edge. A D instruction waiting on div_rd is released in the cycle after div_done. There is no divider-result forwarding.
- Counters:
  - stall_cnt increments every cycle StallF=1.
  - flush_cnt increments every cycle FlushD | FlushE.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current pending/div_busy state. Latency is 0 cycles.
- Scoreboard, div_busy and counters update on the rising edge of clk.
- Reset (asynchronous, rst_n=0) clears pending=0, div_busy=0, stall_cnt=0, flush_cnt=0. This is immediate, mid-operation included. Outputs then follow the combinational rules with an empty scoreboard.
- A divide outstanding at reset is forgotten. A div_done arriving after reset clears an already-clear bit and is harmless.
- A load-use hazard gives exactly 1 bubble.
- A divide dependency stalls D from the cycle the dependent instruction enters D until the cycle after div_done.

## Structure
- Package hazard_pkg holds:
  - the FWD_RF=0, FWD_W=1, FWD_M=2 localparams;
  - the REG_AW/NUM_REGS defaults.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, clr, inc, q), instantiated twice.
- Scoreboard and priority logic stay in the top module.

## Test plan
- Forwarding: RdM=RdW=Rs1E=5 with RegWriteM=RegWriteW=1 gives ForwardAE=2. With RegWriteM=0 it gives 1. With Rs1E=RdM=RdW=0 it gives 0.
- Load-use: ResultSrcE=1, RegWriteE=1, RdE=7, Rs2D=7 with Rs2UsedD=1 gives StallF=StallD=FlushE=1 for 1 cycle. With Rs2UsedD=0 there is no stall.
- Divide scoreboard:
  - Issue DivE with RdE=9. Next cycle pending[9]=1 and div_busy=1.
  - A D instruction reading x9 stalls.
  - Pulse div_done with div_rd=9. Stall drops one cycle later and stall_cnt advances by the stall length.
- Structural and WAW: with div_busy=1, DivD=1 stalls. A RegWriteD instruction with RdD equal to a pending register stalls. Both stop after div_done.
- Priority:
  - dmem_wait=1 with PCSrcE=1 gives StallF..M=FlushW=1 and FlushD=FlushE=0.
  - Releasing dmem_wait gives FlushD=FlushE=1 and StallF=0, even when lwStall is true.
- Reset and counter:
  - Assert rst_n=0 asynchronously mid-stall with pending[9]=1: pending, div_busy and both counters read 0 before the next edge.
  - Hold stall_cnt at all-ones with StallF=1: the value stays. cnt_clr zeroes it.
